// File: rtl/keypoint_reader.sv
// keypoint_reader: scans keypoint SRAM 1 then SRAM 2 into a credit-limited output FIFO.
// Optional build macro KP_BORDER_FILTER_EN drops entries closer than BORDER to the frame edge.
module keypoint_reader #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 11,
    parameter int BORDER = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [11:0]       kp1_count,
    input  logic [11:0]       kp2_count,
    output logic              kp1_re,
    output logic [ADDR_W-1:0] kp1_addr,
    input  logic [18:0]       kp1_dout,
    output logic              kp2_re,
    output logic [ADDR_W-1:0] kp2_addr,
    input  logic [18:0]       kp2_dout,
    output logic              kp_valid,
    input  logic              kp_ready,
    output logic [8:0]        kp_row,
    output logic [9:0]        kp_col,
    output logic              kp_layer,
    output logic              busy,
    output logic              done
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [11:0] MAX_CNT = 12'(1 << ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        FETCH1,
        FETCH2,
        DRAIN,
        FIN
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [11:0]   cnt1;
    logic [11:0]   cnt2;
    logic [11:0]   idx;
    logic [11:0]   cnt1_n;
    logic [11:0]   cnt2_n;
    logic [11:0]   idx_n;
    logic [ADDR_W-1:0] issue_addr;
    logic          issue1;
    logic          issue2;
    logic          inflight;
    logic          inflight_l;
    logic [19:0]   fifo [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_nxt;
    logic          rd_now;
    logic          push;
    logic          pop;
    logic          keep;
    logic          credit;
    logic [18:0]   din;

    function automatic logic [11:0] clamp(input logic [11:0] c);
        return (c > MAX_CNT) ? MAX_CNT : c;
    endfunction

    assign rd_now  = kp1_re | kp2_re;
    assign din     = inflight_l ? kp2_dout : kp1_dout;
    assign push    = inflight & keep;
    assign pop     = kp_valid & kp_ready;
    assign occ_nxt = occ + OW'(push) - OW'(pop);

    // Read enables are registered, so credit is judged on next-cycle occupancy
    // with the read now on the bus counted as the next cycle's in-flight read.
    assign credit = (32'(occ_nxt) + 32'(rd_now)) < 32'(DEPTH);

`ifdef KP_BORDER_FILTER_EN
    assign keep = (din[18:10] >= 9'(BORDER))
               && (din[18:10] <= 9'(479 - BORDER))
               && (din[9:0] >= 10'(BORDER))
               && (din[9:0] <= 10'(639 - BORDER));
`else
    // Without the filter every entry is kept; BORDER is referenced only here.
    assign keep = (BORDER >= 0) | 1'b1;
`endif

    assign kp_valid = (occ != '0);
    assign {kp_layer, kp_row, kp_col} = fifo[rptr];

    always_comb begin
        state_n    = state;
        cnt1_n     = cnt1;
        cnt2_n     = cnt2;
        idx_n      = idx;
        issue1     = 1'b0;
        issue2     = 1'b0;
        issue_addr = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt1_n = clamp(kp1_count);
                    cnt2_n = clamp(kp2_count);
                    idx_n  = '0;
                    if (cnt1_n != '0)
                        state_n = FETCH1;
                    else if (cnt2_n != '0)
                        state_n = FETCH2;
                    else
                        state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (occ == '0 && !inflight && !rd_now)
                    state_n = FIN;
            end
            FIN: state_n = IDLE;
            default: ;
        endcase
        if (state_n == FETCH1 && credit) begin
            issue1     = 1'b1;
            issue_addr = idx_n[ADDR_W-1:0];
            idx_n      = idx_n + 12'd1;
            if (idx_n == cnt1_n) begin
                idx_n   = '0;
                state_n = (cnt2_n != '0) ? FETCH2 : DRAIN;
            end
        end else if (state_n == FETCH2 && credit) begin
            issue2     = 1'b1;
            issue_addr = idx_n[ADDR_W-1:0];
            idx_n      = idx_n + 12'd1;
            if (idx_n == cnt2_n)
                state_n = DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt1       <= '0;
            cnt2       <= '0;
            idx        <= '0;
            kp1_re     <= 1'b0;
            kp2_re     <= 1'b0;
            kp1_addr   <= '0;
            kp2_addr   <= '0;
            inflight   <= 1'b0;
            inflight_l <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            occ        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= '0;
        end else begin
            state  <= state_n;
            cnt1   <= cnt1_n;
            cnt2   <= cnt2_n;
            idx    <= idx_n;
            kp1_re <= issue1;
            kp2_re <= issue2;
            if (state == IDLE && start) begin
                kp1_addr <= '0;
                kp2_addr <= '0;
            end
            if (issue1)
                kp1_addr <= issue_addr;
            if (issue2)
                kp2_addr <= issue_addr;
            inflight   <= rd_now;
            inflight_l <= kp2_re;
            if (push) begin
                fifo[wptr] <= {inflight_l, din};
                wptr       <= wptr + PW'(1);
            end
            if (pop)
                rptr <= rptr + PW'(1);
            occ  <= occ_nxt;
            busy <= (state_n != IDLE);
            done <= (state_n == FIN);
        end
    end

endmodule

// File: tb/tb_keypoint_reader.sv
// Bench for keypoint_reader: scenario table, random scans and reset/border sequences,
// checked against a queue model of the expected keypoint stream.
module tb_keypoint_reader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 11;
    localparam int BORDER = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [11:0]       kp1_count;
    logic [11:0]       kp2_count;
    logic              kp1_re;
    logic [ADDR_W-1:0] kp1_addr;
    logic [18:0]       kp1_dout;
    logic              kp2_re;
    logic [ADDR_W-1:0] kp2_addr;
    logic [18:0]       kp2_dout;
    logic              kp_valid;
    logic              kp_ready;
    logic [8:0]        kp_row;
    logic [9:0]        kp_col;
    logic              kp_layer;
    logic              busy;
    logic              done;

    logic [18:0] mem1 [2048];
    logic [18:0] mem2 [2048];

    int vectors;
    int miscompares;

    typedef struct {
        int c1;
        int c2;
        int rdy_mode;
        int stall_lo;
        int stall_hi;
        int restart_at;
        int exp_first;
        int exp_done;
        int exp_n;
    } scen_t;

    keypoint_reader #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .BORDER(BORDER)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .kp1_count(kp1_count),
        .kp2_count(kp2_count),
        .kp1_re(kp1_re),
        .kp1_addr(kp1_addr),
        .kp1_dout(kp1_dout),
        .kp2_re(kp2_re),
        .kp2_addr(kp2_addr),
        .kp2_dout(kp2_dout),
        .kp_valid(kp_valid),
        .kp_ready(kp_ready),
        .kp_row(kp_row),
        .kp_col(kp_col),
        .kp_layer(kp_layer),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle-latency SRAMs; garbage on the bus when not read
    always @(posedge clk) begin
        kp1_dout <= kp1_re ? mem1[kp1_addr] : 19'($urandom);
        kp2_dout <= kp2_re ? mem2[kp2_addr] : 19'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_window(input logic [18:0] d);
`ifdef KP_BORDER_FILTER_EN
        int r;
        int c;
        r = int'(d[18:10]);
        c = int'(d[9:0]);
        return r >= BORDER && r <= 479 - BORDER
            && c >= BORDER && c <= 639 - BORDER;
`else
        return d == d;
`endif
    endfunction

    function automatic int clamp(input int c);
        return (c > 2048) ? 2048 : c;
    endfunction

    function automatic logic rdy(input scen_t s, input int cyc);
        if (s.rdy_mode == 1)
            return !(cyc >= s.stall_lo && cyc <= s.stall_hi);
        if (s.rdy_mode == 2)
            return $urandom_range(0, 3) != 0;
        return 1'b1;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = 19'($urandom);
            mem2[i] = 19'($urandom);
        end
    endtask

    task automatic run_scan(input scen_t s);
        logic [19:0] q[$];
        logic [19:0] prev;
        logic        hold;
        int cl1, cl2, iss1, iss2, xfers, nexp;
        int cyc, first_v, last_x, last_re, done_c, limit, exp_d;
        cl1 = clamp(s.c1);
        cl2 = clamp(s.c2);
        for (int i = 0; i < cl1; i++)
            if (in_window(mem1[i])) q.push_back({1'b0, mem1[i]});
        for (int i = 0; i < cl2; i++)
            if (in_window(mem2[i])) q.push_back({1'b1, mem2[i]});
        nexp = q.size();
        iss1 = 0; iss2 = 0; xfers = 0;
        first_v = 0; last_x = 0; last_re = 0; done_c = 0;
        hold = 1'b0; prev = '0;
        limit = 4 * (cl1 + cl2) + 100;
        kp1_count = 12'(s.c1);
        kp2_count = 12'(s.c2);
        kp_ready = rdy(s, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < limit && done_c == 0) begin
            kp_ready = rdy(s, cyc);
            start = (cyc == s.restart_at);
            @(negedge clk);
            if (cyc == 1) check("busy_start", 32'(busy), 1);
            if (kp1_re || kp2_re) begin
                check("re_exclusive", 32'(kp1_re & kp2_re), 0);
                check("credit", 32'((iss1 + iss2 + 1 - xfers) <= DEPTH), 1);
                last_re = cyc;
            end
            if (kp1_re) begin
                check("kp1_addr", 32'(kp1_addr), 32'(iss1));
                check("kp1_range", 32'(iss1 < cl1), 1);
                iss1++;
            end
            if (kp2_re) begin
                check("kp2_addr", 32'(kp2_addr), 32'(iss2));
                check("kp2_order", 32'(iss1 == cl1 && iss2 < cl2), 1);
                iss2++;
            end
            if (s.rdy_mode == 1 && cyc >= s.stall_lo + 4 && cyc <= s.stall_hi)
                check("stall_re", 32'(kp1_re | kp2_re), 0);
            if (hold)
                check("hold_stable", 32'({kp_valid, kp_layer, kp_row, kp_col}),
                      32'({1'b1, prev}));
            if (kp_valid && first_v == 0) first_v = cyc;
            if (kp_valid && kp_ready) begin
                if (q.size() == 0)
                    check("extra_xfer", 32'(xfers + 1), 32'(nexp));
                else
                    check("entry", 32'({kp_layer, kp_row, kp_col}), 32'(q.pop_front()));
                xfers++;
                last_x = cyc;
            end
            hold = kp_valid && !kp_ready;
            prev = {kp_layer, kp_row, kp_col};
            if (done) begin
                done_c = cyc;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        if (done_c == 0) begin
            check("done_seen", 32'(done), 1);
        end else begin
            check("busy_fin", 32'(busy), 1);
`ifdef KP_BORDER_FILTER_EN
            check("done_after_reads", 32'(done_c > last_re + 1), 1);
`else
            exp_d = (s.exp_done >= 0) ? s.exp_done : ((nexp > 0) ? last_x + 2 : 2);
            check("done_cycle", 32'(done_c), 32'(exp_d));
            check("first_valid", 32'(first_v), 32'(s.exp_first));
            check("xfers_table", 32'(xfers), 32'(s.exp_n));
`endif
        end
        check("xfers", 32'(xfers), 32'(nexp));
        check("reads", 32'(iss1 + iss2), 32'(cl1 + cl2));
        @(posedge clk);
        #1;
        kp_ready = 1'b1;
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
        check("valid_idle", 32'(kp_valid), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl[8];
        scen_t s;
        int n;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        kp1_count = '0;
        kp2_count = '0;
        kp_ready = 1'b0;

        tbl[0] = '{3, 2, 0, 0, 0, 0, 3, 9, 5};
        tbl[1] = '{20, 0, 1, 4, 15, 0, 3, -1, 20};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 2, 0};
        tbl[3] = '{6, 5, 0, 0, 0, 5, 3, -1, 11};
        tbl[4] = '{0, 4, 0, 0, 0, 0, 3, 8, 4};
        tbl[5] = '{1, 1, 0, 0, 0, 0, 3, 6, 2};
        tbl[6] = '{7, 9, 1, 2, 30, 12, 3, -1, 16};
        tbl[7] = '{3000, 4095, 0, 0, 0, 0, 3, -1, 4096};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_kp1_re", 32'(kp1_re), 0);
        check("rst_kp2_re", 32'(kp2_re), 0);
        check("rst_kp1_addr", 32'(kp1_addr), 0);
        check("rst_kp2_addr", 32'(kp2_addr), 0);
        check("rst_valid", 32'(kp_valid), 0);
        check("rst_data", 32'({kp_layer, kp_row, kp_col}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            fill_mem();
            if (t == 0) begin
                mem1[0] = {9'd5, 10'd10};
                mem1[1] = {9'd6, 10'd20};
                mem1[2] = {9'd7, 10'd30};
                mem2[0] = {9'd100, 10'd200};
                mem2[1] = {9'd101, 10'd201};
            end
            run_scan(tbl[t]);
        end

        for (int r = 0; r < 10; r++) begin
            fill_mem();
            s.c1 = $urandom_range(0, 24);
            s.c2 = $urandom_range(0, 24);
            s.rdy_mode = 2;
            s.stall_lo = 0;
            s.stall_hi = 0;
            s.restart_at = $urandom_range(0, 20);
            s.exp_first = (s.c1 + s.c2 > 0) ? 3 : 0;
            s.exp_done = -1;
            s.exp_n = s.c1 + s.c2;
            run_scan(s);
        end

        // reset asserted during the 5th transfer of a 10-entry scan
        fill_mem();
        kp1_count = 12'd10;
        kp2_count = 12'd0;
        kp_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 7; c++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("xfer5_valid", 32'(kp_valid), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_re", 32'({kp1_re, kp2_re}), 0);
        check("mid_rst_addr", 32'({kp1_addr, kp2_addr}), 0);
        check("mid_rst_valid", 32'(kp_valid), 0);
        check("mid_rst_data", 32'({kp_layer, kp_row, kp_col}), 0);
        check("mid_rst_busy_done", 32'({busy, done}), 0);
        s = '{10, 0, 0, 0, 0, 0, 3, 14, 10};
        run_scan(s);

        // frame-border entries
        fill_mem();
        mem1[0] = {9'd3, 10'd50};
        mem1[1] = {9'd240, 10'd320};
        mem1[2] = {9'd240, 10'd635};
        s = '{3, 0, 0, 0, 0, 0, 3, -1, 3};
        run_scan(s);
`ifdef KP_BORDER_FILTER_EN
        n = 1;
`else
        n = 3;
`endif
        check("border_reads_model", 32'(n), 32'(in_window(mem1[0]) + in_window(mem1[1]) + in_window(mem1[2])));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
